// File: rtl/usb4_ser_pkg.sv
// Purpose: shared encodings, symbol lengths and FSM state type for the lane serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb4_ser_pkg;

   // gen_speed encodings
   localparam logic [1:0] GEN4_BYTE = 2'd0;
   localparam logic [1:0] GEN3      = 2'd1;
   localparam logic [1:0] GEN2      = 2'd2;
   localparam logic [1:0] GEN_RSVD  = 2'd3;

   // Symbol lengths in bits
   localparam int LEN_GEN4 = 8;
   localparam int LEN_GEN3 = 132;
   localparam int LEN_GEN2 = 66;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Symbol length for a gen_speed code; 0 means "do not load".
   function automatic int sym_len(input logic [1:0] gen_speed);
      case (gen_speed)
         GEN4_BYTE: return LEN_GEN4;
         GEN3:      return LEN_GEN3;
         GEN2:      return LEN_GEN2;
         default:   return 0;
      endcase
   endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// Purpose: encoder-to-serializer bus: control, two parallel symbols, serial lanes and status.
// Latency: n/a (wires only).
// Backpressure: sym_req from the serializer paces enable_ser from the encoder.
// Ports: master = encoder/driver side, slave = lane_serializer.
interface lane_serializer_if #(
   parameter int SYM_W = 132
);
   logic             enable;
   logic [1:0]       gen_speed;
   logic             enable_ser;
   logic [SYM_W-1:0] lane_0_tx_enc;
   logic [SYM_W-1:0] lane_1_tx_enc;
   logic             lane_0_tx_out;
   logic             lane_1_tx_out;
   logic             sym_req;
   logic             ser_busy;
   logic             underflow;

   modport master (
      output enable, gen_speed, enable_ser, lane_0_tx_enc, lane_1_tx_enc,
      input  lane_0_tx_out, lane_1_tx_out, sym_req, ser_busy, underflow
   );

   modport slave (
      input  enable, gen_speed, enable_ser, lane_0_tx_enc, lane_1_tx_enc,
      output lane_0_tx_out, lane_1_tx_out, sym_req, ser_busy, underflow
   );
endinterface

// File: rtl/ser_shift_lane.sv
// Purpose: one lane's load/shift register; the serial bit is the register's output end.
// Latency: bit 0 (or bit L-1 when SER_MSB_FIRST_EN) visible one edge after load.
// Backpressure: none; clr > load > shift priority, driven by the top-level FSM.
// Ports: clk/rst (async active-low), clr/load/shift controls, len = symbol length
// for the load, sym_in = parallel symbol, tx_out = serial bit.
// Macro SER_MSB_FIRST_EN: left-align and shift left (MSB first) instead of LSB first.
module ser_shift_lane #(
   parameter int SYM_W = 132,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [CNT_W-1:0] len,
   input  logic [SYM_W-1:0] sym_in,
   output logic             tx_out
);

`ifdef SER_MSB_FIRST_EN
   localparam int OUT_BIT = SYM_W - 1;
`else
   localparam int OUT_BIT = 0;
`endif

   logic [SYM_W-1:0] sreg;
   logic [SYM_W-1:0] ones;
   logic [SYM_W-1:0] masked;
   logic [SYM_W-1:0] aligned;

   // Only the low len bits of the symbol are carried; the rest are zeroed so
   // nothing stale can leak onto the lane after the symbol ends.
   always_comb begin
      ones   = '1;
      masked = sym_in & (ones >> (SYM_W - int'(len)));
`ifdef SER_MSB_FIRST_EN
      aligned = masked << (SYM_W - int'(len));
`else
      aligned = masked;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg <= '0;
      end else if (clr) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= aligned;
      end else if (shift) begin
`ifdef SER_MSB_FIRST_EN
         sreg <= {sreg[SYM_W-2:0], 1'b0};
`else
         sreg <= {1'b0, sreg[SYM_W-1:1]};
`endif
      end
   end

   // The register end bit is itself the output flop.
   assign tx_out = sreg[OUT_BIT];

endmodule

// File: rtl/lane_serializer.sv
// Purpose: two-lane lockstep symbol serializer (Gen4 8b / Gen3 132b / Gen2 66b), one bit per ser_clk.
// Latency: one edge from symbol load to first serial bit; back-to-back symbols with no gap.
// Backpressure: sym_req asks for the next symbol; missing enable_ser at a boundary sets sticky underflow.
// Ports: ser_clk, rst (async active-low), bus (lane_serializer_if.slave): enable, gen_speed,
// enable_ser, lane_x_tx_enc in; lane_x_tx_out, sym_req, ser_busy, underflow out.
// Macro SER_MSB_FIRST_EN: transmit each symbol MSB first (timing unchanged).
module lane_serializer
   import usb4_ser_pkg::*;
#(
   parameter int SYM_W = 132,
   parameter int CNT_W = 8
) (
   input  logic                 ser_clk,
   input  logic                 rst,
   lane_serializer_if.slave     bus
);

   ser_state_e       state;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] len_reg;
   logic [CNT_W-1:0] load_len;
   logic             busy_q;
   logic             uf_q;

   logic at_end;
   logic sym_req;
   logic load;
   logic starve;
   logic clr;
   logic shift;

   always_comb begin
      load_len = CNT_W'(sym_len(bus.gen_speed));
      at_end   = (state == SHIFT) && (bit_cnt == len_reg - 1'b1);
      sym_req  = (state == IDLE) || at_end;
      load     = sym_req && bus.enable_ser && bus.enable && (bus.gen_speed != GEN_RSVD);
      // Last bit of a symbol is going out and nothing replaces it.
      starve   = at_end && bus.enable && !load;
      clr      = !bus.enable || starve;
      shift    = (state == SHIFT) && !at_end && bus.enable;
   end

   always_ff @(posedge ser_clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         len_reg <= '0;
         busy_q  <= 1'b0;
         uf_q    <= 1'b0;
      end else if (!bus.enable) begin
         state   <= IDLE;
         bit_cnt <= '0;
         busy_q  <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  state   <= SHIFT;
                  busy_q  <= 1'b1;
                  len_reg <= load_len;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (load) begin
                  // Back-to-back reload: length re-latched, no gap bit.
                  len_reg <= load_len;
                  bit_cnt <= '0;
               end else if (at_end) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  uf_q    <= 1'b1;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sym_req   = sym_req;
   assign bus.ser_busy  = busy_q;
   assign bus.underflow = uf_q;

   ser_shift_lane #(.SYM_W(SYM_W), .CNT_W(CNT_W)) u_lane_0 (
      .clk    (ser_clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .shift  (shift),
      .len    (load_len),
      .sym_in (bus.lane_0_tx_enc),
      .tx_out (bus.lane_0_tx_out)
   );

   ser_shift_lane #(.SYM_W(SYM_W), .CNT_W(CNT_W)) u_lane_1 (
      .clk    (ser_clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .shift  (shift),
      .len    (load_len),
      .sym_in (bus.lane_1_tx_enc),
      .tx_out (bus.lane_1_tx_out)
   );

endmodule

// File: tb/tb_lane_serializer.sv
// Purpose: self-checking bench for lane_serializer: directed scenarios plus randomized traffic
// against a symbol-level reference model (current symbol + bit position).
// Honours SER_MSB_FIRST_EN for expected bit order.
module tb_lane_serializer;

   localparam int SYM_W = 132;

   logic ser_clk = 1'b0;
   logic rst;

   always #5 ser_clk = ~ser_clk;

   lane_serializer_if #(.SYM_W(SYM_W)) bus();

   lane_serializer #(.SYM_W(SYM_W), .CNT_W(8)) dut (
      .ser_clk (ser_clk),
      .rst     (rst),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit               m_active;
   bit               m_uf;
   int               m_pos;
   int               m_len;
   logic [SYM_W-1:0] m_sym0;
   logic [SYM_W-1:0] m_sym1;

   function automatic int spec_len(input logic [1:0] g);
      case (g)
         2'd0:    return 8;
         2'd1:    return 132;
         2'd2:    return 66;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_req();
      return !m_active || (m_pos == m_len - 1);
   endfunction

   function automatic logic m_bit(input logic [SYM_W-1:0] s);
      if (!m_active) return 1'b0;
`ifdef SER_MSB_FIRST_EN
      return s[m_len - 1 - m_pos];
`else
      return s[m_pos];
`endif
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_uf     = 1'b0;
      m_pos    = 0;
      m_len    = 0;
   endtask

   task automatic model_edge();
      bit req;
      req = m_req();
      if (!bus.enable) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_uf     = 1'b0;
      end else if (req && bus.enable_ser && bus.gen_speed != 2'd3) begin
         m_sym0   = bus.lane_0_tx_enc;
         m_sym1   = bus.lane_1_tx_enc;
         m_len    = spec_len(bus.gen_speed);
         m_pos    = 0;
         m_active = 1'b1;
      end else if (m_active) begin
         if (m_pos == m_len - 1) begin
            m_active = 1'b0;
            m_uf     = 1'b1;
            m_pos    = 0;
         end else begin
            m_pos++;
         end
      end
   endtask

   task automatic check_outs();
      check("lane0_out", bus.lane_0_tx_out, m_bit(m_sym0));
      check("lane1_out", bus.lane_1_tx_out, m_bit(m_sym1));
      check("ser_busy",  bus.ser_busy,      m_active);
      check("underflow", bus.underflow,     m_uf);
   endtask

   // Inputs are already applied; check sym_req, clock once, check registered outputs.
   task automatic step();
      #1;
      check("sym_req", bus.sym_req, m_req());
      @(posedge ser_clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("arst_lane0", bus.lane_0_tx_out, 1'b0);
      check("arst_lane1", bus.lane_1_tx_out, 1'b0);
      check("arst_busy",  bus.ser_busy,      1'b0);
      check("arst_req",   bus.sym_req,       1'b1);
      rst = 1'b1;
   endtask

   function automatic logic [SYM_W-1:0] rnd_sym();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[SYM_W-1:0];
   endfunction

   logic [SYM_W-1:0] sym_a;
   logic [SYM_W-1:0] sym_b;
   logic [3:0]       hdr;
   logic [7:0]       pat0;
   logic [7:0]       pat1;
   logic             exp_bit;
   int               reqs;
   int               bad;
   int               k;

   initial begin
      rst               = 1'b0;
      bus.enable        = 1'b1;
      bus.enable_ser    = 1'b0;
      bus.gen_speed     = 2'd1;
      bus.lane_0_tx_enc = '0;
      bus.lane_1_tx_enc = '0;
      model_reset();

      // Reset values
      #3;
      check("rst_sym_req",   bus.sym_req,       1'b1);
      check("rst_lane0",     bus.lane_0_tx_out, 1'b0);
      check("rst_lane1",     bus.lane_1_tx_out, 1'b0);
      check("rst_busy",      bus.ser_busy,      1'b0);
      check("rst_underflow", bus.underflow,     1'b0);
      @(negedge ser_clk);
      rst = 1'b1;

      // Idle with no symbols
      repeat (10) step();

      // Gen3 single symbol
      bus.gen_speed     = 2'd1;
      bus.lane_0_tx_enc = {128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 4'b0101};
      bus.lane_1_tx_enc = rnd_sym();
      bus.enable_ser    = 1'b1;
      step();
      bus.enable_ser    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hdr[i] = bus.lane_0_tx_out;
         step();
      end
`ifdef SER_MSB_FIRST_EN
      check("g3_first4", {28'd0, hdr}, 32'h0);
`else
      check("g3_first4", {28'd0, hdr}, 32'h5);
`endif
      repeat (128) step();
      check("g3_underflow", bus.underflow,     1'b1);
      check("g3_idle_out",  bus.lane_0_tx_out, 1'b0);
      repeat (3) step();
      bus.enable = 1'b0;
      step();
      check("en0_clears_uf", bus.underflow, 1'b0);
      bus.enable = 1'b1;

      // Gen2 back-to-back
      sym_a             = rnd_sym();
      sym_b             = rnd_sym();
      bus.gen_speed     = 2'd2;
      bus.enable_ser    = 1'b1;
      bus.lane_0_tx_enc = sym_a;
      bus.lane_1_tx_enc = rnd_sym();
      step();
      bus.lane_0_tx_enc = sym_b;
      reqs = 0;
      bad  = 0;
      for (int i = 0; i < 132; i++) begin
`ifdef SER_MSB_FIRST_EN
         exp_bit = (i < 66) ? sym_a[65 - i] : sym_b[65 - (i - 66)];
`else
         exp_bit = (i < 66) ? sym_a[i] : sym_b[i - 66];
`endif
         if (bus.lane_0_tx_out !== exp_bit) bad++;
         if (i == 70) bus.enable_ser = 1'b0;
         if (bus.sym_req) reqs++;
         step();
      end
      check("g2_stream_errs", bad,  0);
      check("g2_req_pulses",  reqs, 2);
      check("g2_underflow",   bus.underflow, 1'b1);
      bus.enable = 1'b0;
      step();
      bus.enable = 1'b1;

      // Gen4 byte path, held symbol
      pat0              = 8'h01;
      pat1              = 8'hA5;
      bus.gen_speed     = 2'd0;
      bus.lane_0_tx_enc = rnd_sym();
      bus.lane_1_tx_enc = rnd_sym();
      bus.lane_0_tx_enc[7:0] = pat0;
      bus.lane_1_tx_enc[7:0] = pat1;
      bus.enable_ser    = 1'b1;
      step();
      for (int i = 0; i < 32; i++) begin
`ifdef SER_MSB_FIRST_EN
         check("g4_lane1_bit", bus.lane_1_tx_out, pat1[7 - (i % 8)]);
         check("g4_lane0_bit", bus.lane_0_tx_out, pat0[7 - (i % 8)]);
`else
         check("g4_lane1_bit", bus.lane_1_tx_out, pat1[i % 8]);
         check("g4_lane0_bit", bus.lane_0_tx_out, pat0[i % 8]);
`endif
         step();
      end
      check("g4_no_underflow", bus.underflow, 1'b0);
      bus.enable = 1'b0;
      step();
      bus.enable = 1'b1;

      // gen_speed 1->2 at bit 40: current stays 132, next is 66
      bus.gen_speed     = 2'd1;
      bus.lane_0_tx_enc = rnd_sym();
      bus.lane_1_tx_enc = rnd_sym();
      bus.enable_ser    = 1'b1;
      step();
      k = 0;
      while (!bus.sym_req && k < 300) begin
         if (k == 40) bus.gen_speed = 2'd2;
         step();
         k++;
      end
      check("mid_gen_len_cur", k, 131);
      bus.lane_0_tx_enc = rnd_sym();
      step();
      k = 0;
      while (!bus.sym_req && k < 300) begin
         step();
         k++;
      end
      check("mid_gen_len_next", k, 65);

      // enable=0 at bit 40
      step();
      repeat (40) step();
      bus.enable = 1'b0;
      step();
      check("en0_lane0", bus.lane_0_tx_out, 1'b0);
      check("en0_busy",  bus.ser_busy,      1'b0);
      check("en0_uf",    bus.underflow,     1'b0);
      check("en0_req",   bus.sym_req,       1'b1);
      bus.enable     = 1'b1;
      bus.enable_ser = 1'b0;
      step();

      // Randomized traffic with occasional async reset
      for (int i = 0; i < 4000; i++) begin
         bus.enable        = ($urandom % 40) != 0;
         bus.enable_ser    = ($urandom % 5) != 0;
         if (($urandom % 16) == 0) bus.gen_speed = 2'($urandom % 4);
         bus.lane_0_tx_enc = rnd_sym();
         bus.lane_1_tx_enc = rnd_sym();
         step();
         if (($urandom % 400) == 0) pulse_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
